shift_rotate_sequencer: RTL

//  Multi-step shift/rotate controller placed directly upstream of the 8-bit

---
 rtl/shift_rotate_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/shift_rotate_sequencer.sv
// Purpose : multi-step shift/rotate controller that iterates an external 1-bit shifter stage 'amount' times.
// Latency : done pulses amount+1 cycles after the accepted start cycle (amount=0 -> the next cycle).
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           request, sampled only in IDLE
//   data_in/op/amount  operand, operation (00 shl, 01 shr, 10 rotl, 11 rotr) and step count, captured on accepted start
//   sh_x, sh_sel    registered drive to the combinational shifter stage
//   sh_y            one-step result of sh_x from the shifter stage
//   busy            high whenever the sequencer is not idle
//   done            one-cycle completion pulse
//   result          working register; valid from done until the next accepted start
module shift_rotate_sequencer #(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       data_in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  output logic [7:0]       sh_x,
  output logic [1:0]       sh_sel,
  input  logic [7:0]       sh_y,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       work;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] cnt;

  // State register plus the datapath registers it controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      work  <= 8'h00;
      op_q  <= 2'b00;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            work <= data_in;
            op_q <= op;
            cnt  <= amount;
          end
        end
        RUN: begin
          // The shifter is combinational, so sh_y already reflects one step of work.
          work <= sh_y;
          if (cnt != '0) begin
            cnt <= cnt - AMT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (amount == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // cnt==1 means this edge applies the final step; <= also guards a stale zero.
        if (cnt <= AMT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs are plain decodes of registers: no input-to-output paths.
  assign sh_x   = work;
  assign sh_sel = op_q;
  assign result = work;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule
